mem_wb_register: RTL and testbench
==================================

// Module: mem_wb_register
// PURPOSE
//  MEM/WB pipeline register and write-back data former for the 5-stage MIPS core.
//  - Captures MEM-stage results each cycle.
//  - Extracts and extends sub-word load data, then selects the write-back source.
//  - Drives RegWrite_wb, RegWriteAddr_wb and RegWriteData_wb.
//  - Consumers: the register-file write port and the ID-stage forwarding detector (RAW bypass).
// PARAMETERS
//  DATA_W         32  datapath width; only 32 is supported
//  REG_ADDR_W     5   register-address width
//  ZERO_SUPPRESS  1   1: a write to $0 is registered with RegWrite_wb=0
// PORTS
//  clk               in   1   core clock; all state updates on rising edge
//  rst_n             in   1   synchronous reset, active-low
//  Stall             in   1   hold all WB registers at their current value
//  Flush             in   1   load a bubble into WB
//  RegWrite_mem      in   1   MEM-stage instruction writes a register
//  RegWriteAddr_mem  in   5   destination register number
//  MemtoReg_mem      in   1   result comes from data memory
//  Link_mem          in   1   result is the return address (jal/jalr)
//  LoadType_mem      in   3   000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101-111 treated as lw
//  ByteOffset_mem    in   2   AluResult_mem[1:0], the byte lane of the load
//  AluResult_mem     in   32  ALU result
//  MemReadData_mem   in   32  raw word from data memory, valid in the MEM cycle
//  PCPlus8_mem       in   32  link address
//  RegWrite_wb       out  1   registered write enable
//  RegWriteAddr_wb   out  5   registered destination
//  RegWriteData_wb   out  32  registered write data
//  Valid_wb          out  1   WB holds a real instruction, not a bubble
// BEHAVIOUR
//  - Reset: on any clock edge with rst_n=0, all outputs go to 0. Reset overrides Stall and Flush.
//  - Latency: exactly 1 cycle. All outputs come directly from flops; no combinational input->output path.
//  - Update priority each edge: rst_n=0 > Flush > Stall > normal capture.
//  - Flush: RegWrite_wb=0, RegWriteAddr_wb=0, RegWriteData_wb=0, Valid_wb=0.
//  - Stall (no Flush): every output holds its value. Flush+Stall together produce a bubble.
//  - Normal capture:
//    - Valid_wb <= 1.
//    - RegWriteAddr_wb <= RegWriteAddr_mem.
//    - RegWrite_wb <= RegWrite_mem, ANDed with (RegWriteAddr_mem!=0) when ZERO_SUPPRESS=1.
//  - Load extraction is combinational in front of the flops; byte order is little-endian.
//    - Byte lane k = MemReadData_mem[8k+7:8k], with k = ByteOffset_mem.
//    - Half lane = ByteOffset_mem[1]: 0 -> [15:0], 1 -> [31:16]. ByteOffset_mem[0] is ignored for lh/lhu.
//    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word and ignores ByteOffset_mem.
//  - Data select priority: Link_mem -> PCPlus8_mem; else MemtoReg_mem -> extracted load; else AluResult_mem.
//  - Data flops load the selected value even when RegWrite_mem=0; the value is don't-care to consumers.
//  - Reset in mid-stream: the first capture after rst_n returns high takes MEM inputs normally. Nothing is replayed.
// TESTING
//  - Reset: rst_n=0 for 2 clk with Stall=1 and Flush=1 -> all outputs 0; Valid_wb=0.
//  - Capture: RegWrite=1, Addr=8, AluResult=32'h0000_1234, MemtoReg=0, Link=0
//    -> next cycle RegWrite_wb=1, Addr_wb=8, Data_wb=32'h0000_1234, Valid_wb=1.
//  - Loads, MemRead=32'h80FF_7F01, MemtoReg=1:
//    - lb off=3 -> 32'hFFFF_FF80
//    - lbu off=3 -> 32'h0000_0080
//    - lh off=2 -> 32'hFFFF_80FF
//    - lhu off=1 -> 32'h0000_7F01
//    - lw off=2 -> 32'h80FF_7F01
//  - Link priority: Link=1, MemtoReg=1, PCPlus8=32'h0040_0010, Addr=31 -> Data_wb=32'h0040_0010, Addr_wb=31.
//  - $0 suppression: RegWrite=1, Addr=0 -> RegWrite_wb=0, Valid_wb=1.
//  - Stall/Flush: after capture of Addr=5, Stall=1 for 3 cycles while inputs change -> outputs unchanged;
//    then Flush=1 with Stall=1 -> bubble (all 0, Valid_wb=0).

Source files
------------

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: forms the write-back value (sub-word load extraction
// and source select) in front of the flops and registers the register-file write.
module mem_wb_register #(
  parameter int DATA_W        = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  RegWrite_mem,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_mem,
  input  logic                  MemtoReg_mem,
  input  logic                  Link_mem,
  input  logic [2:0]            LoadType_mem,
  input  logic [1:0]            ByteOffset_mem,
  input  logic [DATA_W-1:0]     AluResult_mem,
  input  logic [DATA_W-1:0]     MemReadData_mem,
  input  logic [DATA_W-1:0]     PCPlus8_mem,
  output logic                  RegWrite_wb,
  output logic [REG_ADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0]     RegWriteData_wb,
  output logic                  Valid_wb
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] wbData;
  logic              regWriteNext;

  // Little-endian lanes; the half lane ignores ByteOffset_mem[0].
  always_comb begin
    loadByte = MemReadData_mem[7:0];
    case (ByteOffset_mem)
      2'd0: loadByte = MemReadData_mem[7:0];
      2'd1: loadByte = MemReadData_mem[15:8];
      2'd2: loadByte = MemReadData_mem[23:16];
      2'd3: loadByte = MemReadData_mem[31:24];
      default: loadByte = MemReadData_mem[7:0];
    endcase
    loadHalf = ByteOffset_mem[1] ? MemReadData_mem[31:16] : MemReadData_mem[15:0];
  end

  // Unassigned load-type codes fall back to a full-word load.
  always_comb begin
    loadData = MemReadData_mem;
    case (LoadType_mem)
      LT_LB:   loadData = {{(DATA_W-8){loadByte[7]}}, loadByte};
      LT_LBU:  loadData = {{(DATA_W-8){1'b0}}, loadByte};
      LT_LH:   loadData = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
      LT_LHU:  loadData = {{(DATA_W-16){1'b0}}, loadHalf};
      default: loadData = MemReadData_mem;
    endcase
  end

  always_comb begin
    wbData = AluResult_mem;
    if (Link_mem)
      wbData = PCPlus8_mem;
    else if (MemtoReg_mem)
      wbData = loadData;
    regWriteNext = RegWrite_mem &
                   ((ZERO_SUPPRESS == 0) || (RegWriteAddr_mem != '0));
  end

  // Priority: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite_wb     <= 1'b0;
      RegWriteAddr_wb <= '0;
      RegWriteData_wb <= '0;
      Valid_wb        <= 1'b0;
    end else if (Flush) begin
      RegWrite_wb     <= 1'b0;
      RegWriteAddr_wb <= '0;
      RegWriteData_wb <= '0;
      Valid_wb        <= 1'b0;
    end else if (!Stall) begin
      RegWrite_wb     <= regWriteNext;
      RegWriteAddr_wb <= RegWriteAddr_mem;
      RegWriteData_wb <= wbData;
      Valid_wb        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_register.sv
// Self-checking bench for mem_wb_register: directed checks of the documented
// cases followed by randomized traffic against an arithmetic reference model.
module tb_mem_wb_register;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        regWriteMem;
  logic [4:0]  regWriteAddrMem;
  logic        memtoRegMem;
  logic        linkMem;
  logic [2:0]  loadTypeMem;
  logic [1:0]  byteOffsetMem;
  logic [31:0] aluResultMem;
  logic [31:0] memReadDataMem;
  logic [31:0] pcPlus8Mem;
  logic        regWriteWb;
  logic [4:0]  regWriteAddrWb;
  logic [31:0] regWriteDataWb;
  logic        validWb;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what WB should hold after the most recent edge.
  logic        expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  logic        expValid;

  mem_wb_register dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Stall            (stall),
    .Flush            (flush),
    .RegWrite_mem     (regWriteMem),
    .RegWriteAddr_mem (regWriteAddrMem),
    .MemtoReg_mem     (memtoRegMem),
    .Link_mem         (linkMem),
    .LoadType_mem     (loadTypeMem),
    .ByteOffset_mem   (byteOffsetMem),
    .AluResult_mem    (aluResultMem),
    .MemReadData_mem  (memReadDataMem),
    .PCPlus8_mem      (pcPlus8Mem),
    .RegWrite_wb      (regWriteWb),
    .RegWriteAddr_wb  (regWriteAddrWb),
    .RegWriteData_wb  (regWriteDataWb),
    .Valid_wb         (validWb)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads computed by shifting and masking, sign handled by arithmetic offset.
  function automatic logic [31:0] refLoad(input logic [2:0] lt, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  task automatic modelEdge();
    if (!rst_n || flush) begin
      expWe = 1'b0; expAddr = '0; expData = '0; expValid = 1'b0;
    end else if (!stall) begin
      expWe    = regWriteMem && (regWriteAddrMem != 5'd0);
      expAddr  = regWriteAddrMem;
      expData  = linkMem ? pcPlus8Mem :
                 memtoRegMem ? refLoad(loadTypeMem, byteOffsetMem, memReadDataMem) :
                 aluResultMem;
      expValid = 1'b1;
    end
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".we"},    {31'd0, regWriteWb}, {31'd0, expWe});
    check({tag, ".addr"},  {27'd0, regWriteAddrWb}, {27'd0, expAddr});
    check({tag, ".data"},  regWriteDataWb, expData);
    check({tag, ".valid"}, {31'd0, validWb}, {31'd0, expValid});
  endtask

  // Driver: model the edge from the current inputs, then sample 1 time unit later.
  task automatic cycle(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic setOp(input logic we, input logic [4:0] addr, input logic m2r,
                       input logic lnk, input logic [2:0] lt, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc8);
    regWriteMem = we; regWriteAddrMem = addr; memtoRegMem = m2r; linkMem = lnk;
    loadTypeMem = lt; byteOffsetMem = off; aluResultMem = alu;
    memReadDataMem = rd; pcPlus8Mem = pc8;
  endtask

  task automatic randomOp();
    setOp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    setOp(1'b1, 5'd7, 1'b0, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h1, 32'h2);
    expWe = 1'bx; expAddr = 'x; expData = 'x; expValid = 1'bx;
    @(posedge clk); #1;

    // Reset with Stall and Flush asserted
    cycle("reset0");
    cycle("reset1");
    check("reset.data.const", regWriteDataWb, 32'h0);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;

    // Plain ALU capture
    setOp(1'b1, 5'd8, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0);
    cycle("alu");
    check("alu.data.const", regWriteDataWb, 32'h0000_1234);

    // Sub-word loads from one memory word
    setOp(1'b1, 5'd9, 1'b1, 1'b0, 3'd1, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0);
    cycle("lb3");  check("lb3.const", regWriteDataWb, 32'hFFFF_FF80);
    loadTypeMem = 3'd2; cycle("lbu3"); check("lbu3.const", regWriteDataWb, 32'h0000_0080);
    loadTypeMem = 3'd3; byteOffsetMem = 2'd2;
    cycle("lh2");  check("lh2.const", regWriteDataWb, 32'hFFFF_80FF);
    loadTypeMem = 3'd4; byteOffsetMem = 2'd1;
    cycle("lhu1"); check("lhu1.const", regWriteDataWb, 32'h0000_7F01);
    loadTypeMem = 3'd0; byteOffsetMem = 2'd2;
    cycle("lw2");  check("lw2.const", regWriteDataWb, 32'h80FF_7F01);
    loadTypeMem = 3'd6; byteOffsetMem = 2'd1;
    cycle("lt6");  check("lt6.const", regWriteDataWb, 32'h80FF_7F01);

    // Link takes priority over MemtoReg
    setOp(1'b1, 5'd31, 1'b1, 1'b1, 3'd1, 2'd0, 32'h5, 32'h80FF_7F01, 32'h0040_0010);
    cycle("link"); check("link.const", regWriteDataWb, 32'h0040_0010);

    // Write to $0 is suppressed but still a valid instruction
    setOp(1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
    cycle("zero"); check("zero.we.const", {31'd0, regWriteWb}, 32'd0);

    // Stall holds while inputs change, then Flush+Stall gives a bubble
    setOp(1'b1, 5'd5, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0000_0555, 32'h0, 32'h0);
    cycle("cap5");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomOp();
      cycle("stall");
      check("stall.addr.const", {27'd0, regWriteAddrWb}, 32'd5);
    end
    flush = 1'b1;
    cycle("flush"); check("flush.valid.const", {31'd0, validWb}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic, including mid-stream resets
    for (int i = 0; i < 400; i++) begin
      randomOp();
      rst_n = ($urandom_range(0, 31) != 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
